// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serialiser.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit to each frame).
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_t;

    // Counter width for a modulus of n: never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/piso_bit_tick.sv
// Bit-period divider: pulses tick on the last cycle of every DIV-cycle bit period.
// Held at zero while run is low so each frame starts on a fresh period.
module piso_bit_tick
    import piso_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned DW = cnt_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] cnt_q;

    // Count 0..DIV-1 while running, wrap on the last cycle, clear when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!run || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = run & (cnt_q == LAST);

endmodule

// File: rtl/piso_stream.sv
// Parametrised parallel-in/serial-out shifter with valid/ready load and framed output.
// Optional feature macro: PISO_PARITY_EN (even-parity bit appended after the data bits).
module piso_stream
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned DIV       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             s_out,
    output logic             s_valid,
    output logic             done
);

    localparam int unsigned    BW       = $clog2(WIDTH + 2);
    localparam int unsigned    FL       = WIDTH + (PARITY_EN ? 1 : 0);
    localparam logic [BW-1:0]  LAST_BIT = BW'(FL - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [BW-1:0]    bit_cnt_q;
    logic             armed_q;

    logic             run;
    logic             tick;
    logic             last;
    logic             accept;
    logic             data_bit;
    logic             cur_bit;
    logic [WIDTH-1:0] sreg_shifted;

    assign run = (state_q == SHIFT);

    piso_bit_tick #(
        .DIV (DIV)
    ) u_bit_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // Outgoing data bit sits at the end selected by MSB_FIRST; shifts zero-fill
    assign data_bit     = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Parity of the captured word, replayed as the final frame bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^parallel_in;
        end
    end

    assign cur_bit = (bit_cnt_q == BW'(WIDTH)) ? parity_q : data_bit;
`else
    assign cur_bit = data_bit;
`endif

    // Last cycle of the last frame bit: frame ends here and a new word may be taken
    assign last     = run & tick & (bit_cnt_q == LAST_BIT);
    assign in_ready = armed_q & ((state_q == IDLE) | last);
    assign accept   = in_valid & in_ready;

    assign s_valid  = run;
    assign s_out    = run & cur_bit;
    assign done     = last;

    // Frame FSM: load on accept, shift on each bit tick, return to IDLE after the last bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            // in_ready stays low until the first edge after reset release
            armed_q <= 1'b1;
            if (accept) begin
                state_q   <= SHIFT;
                sreg_q    <= parallel_in;
                bit_cnt_q <= '0;
            end else if (run && tick) begin
                sreg_q <= sreg_shifted;
                if (last) begin
                    state_q   <= IDLE;
                    bit_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter; successor to the fixed 4-bit PISO.
- Adds configurable width, shift direction, per-bit hold time and a valid/ready load handshake.
- Emits a framed serial stream with a frame-active flag and an end-of-frame pulse.
- Sits between a parallel data producer and any bit-serial sink: test pins, simple serial links, LED/DAC shift chains.

Parameters:
- WIDTH, 8: parallel word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- DIV, 1: clock cycles each bit is held on s_out; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- in_valid  in  1  parallel_in holds a word to load.
- in_ready  out  1  block can accept a word this cycle.
- parallel_in  in  WIDTH  word to serialise; sampled only on accept.
- s_out  out  1  serial data.
- s_valid  out  1  high while s_out carries a frame bit.
- done  out  1  one-cycle pulse during the final cycle of a frame's last bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, counters=0.
  - s_out=0, s_valid=0, done=0, in_ready=0 while rst is low.
- After reset release: in_ready=1 in IDLE.
- States:
  - IDLE: s_valid=0, s_out=0, in_ready=1.
  - SHIFT: s_valid=1, in_ready=0 except in the last cycle of the last bit.
- Accept: happens on a rising edge where in_valid and in_ready are both 1.
  - The word is captured into the shift register and state goes to SHIFT.
  - The first bit appears on s_out in the next cycle. Latency is 1 cycle from accept edge to first bit.
- Bit timing: with accept at edge k, frame bit i is on s_out for cycles k+1+i*DIV through k+(i+1)*DIV.
- Frame length FL: WIDTH bits, or WIDTH+1 with the optional feature.
- Divider counter counts 0..DIV-1.
  - On wrap, the register shifts: left if MSB_FIRST, right otherwise, zero fill.
  - On the same wrap the bit counter increments.
- Last cycle of the last bit:
  - done=1 and in_ready=1.
  - If a word is accepted on that edge, the next frame's first bit follows with no gap and s_valid stays high. done still pulses for the finished frame.
  - If nothing is accepted, the next cycle returns to IDLE.
- in_valid outside an accept window is ignored; parallel_in changes during SHIFT have no effect.
- Width rules:
  - bit counter is $clog2(WIDTH+2) bits.
  - divider is max(1,$clog2(DIV)) bits.
  - DIV=1 means the divider is always at wrap.
- Reset mid-frame aborts the frame: no done, all outputs go to reset values.
- No data is lost or reordered; one accept produces exactly one frame.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit equal to XOR of the captured word is appended after the data bits, so FL=WIDTH+1.
  - It is held for DIV cycles and s_valid stays high during it.
  - done and in_ready move to the last cycle of the parity bit.
- Undefined: FL=WIDTH, with no parity logic or storage.

Decomposition:
- Package piso_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - a localparam function for counter widths;
  - the parity-enable localparam derived from the macro.
- One sub-module, piso_bit_tick.
  - Implements the DIV divider.
  - Inputs: clk, rst, run. Output: tick on the last cycle of each bit period.
  - Clears to 0 whenever run=0.

Test Plan:
- Basic MSB-first: WIDTH=4, DIV=1, MSB_FIRST=1; accept 4'b1010 at edge k.
  - s_out=1,0,1,0 on cycles k+1..k+4.
  - s_valid high for exactly those 4 cycles.
  - done only at k+4.
  - Then IDLE with s_out=0.
- LSB-first: same stimulus with MSB_FIRST=0.
  - s_out=0,1,0,1 on cycles k+1..k+4.
- Divided rate: WIDTH=4, DIV=3, word 4'b1100.
  - s_out=1 for 6 cycles, then 0 for 6 cycles.
  - done at cycle k+12 only.
  - in_ready=0 throughout except k+12.
- Back-to-back: hold in_valid=1 with 4'b1010 followed by 4'b0110.
  - Continuous 1,0,1,0,0,1,1,0 with s_valid never dropping.
  - done pulses twice, 4 cycles apart.
- Reset mid-frame: pull rst low at bit 2 of a frame, asynchronously between clock edges.
  - s_out, s_valid and in_ready go to 0 immediately; no done.
  - After release, a new word 4'b0001 serialises correctly.
- Parity (PISO_PARITY_EN defined): WIDTH=4, DIV=1, word 4'b1011.
  - s_out=1,0,1,1,1 (parity=1).
  - done at cycle k+5.
  - Word 4'b0011 gives parity bit 0.
